// File: rtl/ram_moc_responder.sv
// Word-addressed data memory answering the MOV/MOC four-phase handshake
// after WAIT_CYCLES wait states, with an access-fault flag for bad addresses.
`timescale 1ns/1ps

module ram_moc_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mov,
    input  logic        rw,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        moc,
    output logic        err
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic            r_rw;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_dout;
    logic            r_moc;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic            w_access;
    logic            w_fault;
    logic [AW-1:0]   w_index;
    logic [31:0]     w_rdata;

    assign w_fault  = (r_addr[1:0] != 2'b00) || ({1'b0, r_addr} >= LIMIT);
    assign w_index  = r_addr[AW+1:2];
    assign w_rdata  = r_mem[w_index];
    assign data_out = r_dout;
    assign moc      = r_moc;
    assign err      = r_err;

    always_comb begin
        w_next   = r_state;
        w_access = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && mov) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mov) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next   = S_DONE;
                    w_access = 1'b1;
                end
            end
            S_DONE: begin
                if (!mov) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_dout  <= 32'd0;
            r_moc   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (enable && mov) begin
                        r_rw    <= rw;
                        r_addr  <= address;
                        r_wdata <= data_in;
                        r_cnt   <= 4'(WAIT_CYCLES);
                    end
                end
                S_WAIT: begin
                    if (w_access) begin
                        r_moc <= 1'b1;
                        r_err <= w_fault;
                        if (w_fault) begin
                            r_dout <= 32'd0;
                        end else if (r_rw) begin
                            r_dout <= w_rdata;
                        end
                    end else if (mov) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!mov) begin
                        r_moc <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain; writes only happen on the completing edge.
    always_ff @(posedge clk) begin
        if (w_access && !r_rw && !w_fault) begin
            r_mem[w_index] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_ram_moc_responder.sv
// Scoreboard bench for ram_moc_responder: instance 0 uses two wait states,
// instance 1 zero wait states; a reference memory model predicts every completion.
`timescale 1ns/1ps

module tb_ram_moc_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        known;
        logic        errBit;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        enable  [2];
    logic        mov     [2];
    logic        rw      [2];
    logic [31:0] address [2];
    logic [31:0] dataIn  [2];
    logic [31:0] dataOut [2];
    logic        moc     [2];
    logic        err     [2];

    int compared   = 0;
    int mismatched = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t monE;
    logic prevMoc [2];

    logic [31:0] refMem   [2][128];
    bit          refValid [2][128];
    logic [31:0] lastDout [2];
    bit          lastKnown[2];

    ram_moc_responder #(.DEPTH(128), .WAIT_CYCLES(2)) dutSlow (
        .clk(clk), .reset(rstN), .enable(enable[0]), .mov(mov[0]), .rw(rw[0]),
        .address(address[0]), .data_in(dataIn[0]), .data_out(dataOut[0]),
        .moc(moc[0]), .err(err[0])
    );

    ram_moc_responder #(.DEPTH(128), .WAIT_CYCLES(0)) dutFast (
        .clk(clk), .reset(rstN), .enable(enable[1]), .mov(mov[1]), .rw(rw[1]),
        .address(address[1]), .data_in(dataIn[1]), .data_out(dataOut[1]),
        .moc(moc[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: resolve a request against the abstract memory and queue the result.
    task automatic modelIssue(input int d, input bit rwBit, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   idx;
        idx = int'(addr[8:2]);
        if (addr[1:0] != 2'b00 || addr >= 32'd512) begin
            e = '{data: 32'd0, known: 1'b1, errBit: 1'b1};
            lastDout[d]  = 32'd0;
            lastKnown[d] = 1'b1;
        end else if (rwBit) begin
            e = '{data: refMem[d][idx], known: refValid[d][idx], errBit: 1'b0};
            lastDout[d]  = refMem[d][idx];
            lastKnown[d] = refValid[d][idx];
        end else begin
            refMem[d][idx]   = wdata;
            refValid[d][idx] = 1'b1;
            e = '{data: lastDout[d], known: lastKnown[d], errBit: 1'b0};
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic scramble(input int d);
        enable[d]  = 1'($urandom_range(0, 1));
        address[d] = $urandom;
        dataIn[d]  = $urandom;
    endtask

    task automatic applyStimulus(input int d, input bit rwBit, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int abortAfter, input int hold);
        int          w;
        logic [31:0] riseDout;
        logic        ok;
        w = (d == 0) ? 2 : 0;
        @(negedge clk);
        enable[d]  = 1'b1;
        mov[d]     = 1'b1;
        rw[d]      = rwBit;
        address[d] = addr;
        dataIn[d]  = wdata;
        @(posedge clk);
        if (abortAfter < 0) modelIssue(d, rwBit, addr, wdata);
        #1;
        ok = 1'b1;
        if (abortAfter >= 0) begin
            for (int k = 0; k < abortAfter; k++) begin
                @(negedge clk); scramble(d);
                @(posedge clk); #1;
                if (moc[d]) ok = 1'b0;
            end
            @(negedge clk);
            mov[d]    = 1'b0;
            enable[d] = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (moc[d]) ok = 1'b0;
            end
            checkOutput("abort_no_moc", 32'(ok), 32'd1);
        end else begin
            for (int k = 1; k <= w + 1; k++) begin
                @(negedge clk); scramble(d);
                @(posedge clk); #1;
                if (moc[d] != (k == w + 1)) ok = 1'b0;
            end
            checkOutput("moc_latency", 32'(ok), 32'd1);
            riseDout = dataOut[d];
            repeat (hold) begin
                @(negedge clk); scramble(d);
                @(posedge clk); #1;
                checkOutput("hold_moc", 32'(moc[d]), 32'd1);
                checkOutput("hold_data", dataOut[d], riseDout);
            end
            @(negedge clk);
            mov[d]    = 1'b0;
            enable[d] = 1'b0;
            @(posedge clk); #1;
            checkOutput("moc_fall", 32'(moc[d]), 32'd0);
            checkOutput("err_fall", 32'(err[d]), 32'd0);
            checkOutput("data_keep", dataOut[d], riseDout);
        end
    endtask

    // Monitor: every rising moc consumes one predicted completion.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (moc[d] && !prevMoc[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_moc: instance %0d raised moc with nothing expected", d);
                end else begin
                    monE = (d == 0) ? q0.pop_front() : q1.pop_front();
                    checkOutput("resp_err", 32'(err[d]), 32'(monE.errBit));
                    if (monE.known) checkOutput("resp_data", dataOut[d], monE.data);
                end
            end
            prevMoc[d] = moc[d];
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] addr;
        int          d;
        int          r;
        int          ab;
        rstN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            enable[i] = 1'b0; mov[i] = 1'b0; rw[i] = 1'b0;
            address[i] = 32'd0; dataIn[i] = 32'd0;
            prevMoc[i] = 1'b0; lastDout[i] = 32'd0; lastKnown[i] = 1'b1;
            for (int j = 0; j < 128; j++) begin
                refMem[i][j] = 32'd0; refValid[i][j] = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_moc", 32'(moc[i]), 32'd0);
            checkOutput("reset_err", 32'(err[i]), 32'd0);
            checkOutput("reset_data", dataOut[i], 32'd0);
        end
        @(negedge clk) rstN = 1'b1;
        $display("[TB] reset released");

        applyStimulus(0, 1'b0, 32'h10, 32'hDEADBEEF, -1, 0);
        applyStimulus(0, 1'b1, 32'h10, 32'h0, -1, 0);

        applyStimulus(1, 1'b0, 32'h1FC, 32'h12345678, -1, 0);
        applyStimulus(1, 1'b1, 32'h1FC, 32'h0, -1, 0);

        applyStimulus(0, 1'b0, 32'h0, 32'h0BADF00D, -1, 0);
        applyStimulus(0, 1'b1, 32'h202, 32'h0, -1, 1);
        applyStimulus(0, 1'b0, 32'h200, 32'hCAFECAFE, -1, 0);
        applyStimulus(0, 1'b1, 32'h0, 32'h0, -1, 0);

        applyStimulus(0, 1'b0, 32'h20, 32'h11112222, -1, 0);
        applyStimulus(0, 1'b0, 32'h20, 32'hAAAA5555, 1, 0);
        applyStimulus(0, 1'b0, 32'h20, 32'hBBBB6666, 2, 0);
        applyStimulus(0, 1'b1, 32'h20, 32'h0, -1, 0);

        applyStimulus(0, 1'b0, 32'h30, 32'h33334444, -1, 0);
        applyStimulus(0, 1'b1, 32'h30, 32'h0, -1, 0);
        @(negedge clk);
        enable[0] = 1'b1; mov[0] = 1'b1; rw[0] = 1'b0;
        address[0] = 32'h30; dataIn[0] = 32'h99999999;
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_moc", 32'(moc[0]), 32'd0);
        checkOutput("midreset_err", 32'(err[0]), 32'd0);
        checkOutput("midreset_data", dataOut[0], 32'd0);
        mov[0] = 1'b0; enable[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lastDout[i] = 32'd0; lastKnown[i] = 1'b1;
        end
        @(negedge clk) rstN = 1'b1;
        applyStimulus(0, 1'b1, 32'h30, 32'h0, -1, 0);

        applyStimulus(0, 1'b1, 32'h10, 32'h0, -1, 5);

        for (int n = 0; n < 200; n++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 19));
            if (r == 0)      addr = 32'h200 + 32'($urandom_range(0, 63)) * 4;
            else if (r == 1) addr = 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 2) addr = 32'h1FC;
            else if (r == 3) addr = 32'hFFFFFFFC;
            else             addr = 32'($urandom_range(0, 15)) * 4;
            ab = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, (d == 0) ? 2 : 0)) : -1;
            applyStimulus(d, 1'($urandom_range(0, 1)), addr, $urandom, ab, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_moc_responder.md
# ram_moc_responder

Memory-side responder for the processor's MOV/MOC data-memory handshake. The datapath raises a request with enable, mov, rw, address and write data. This block performs the word access into its internal storage after a programmable number of wait states, then raises moc. It completes a four-phase handshake and replaces the zero-latency data RAM so that load/store stalls in the control unit are exercised.

## Interface
Parameters:
- DEPTH, 128: number of 32-bit words stored; byte address range is 0 .. 4*DEPTH-1.
- WAIT_CYCLES, 2: wait states between request capture and completion; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  memory select (RAMEnable); a request needs enable=1 and mov=1.
- mov  input  1  memory operation valid; held high by the initiator until moc is seen.
- rw  input  1  1 = read, 0 = write.
- address  input  32  byte address; must be word-aligned.
- data_in  input  32  write data.
- data_out  output  32  read data; registered.
- moc  output  1  memory operation complete; registered.
- err  output  1  access fault (misaligned or out of range); valid while moc=1.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - When enable & mov are both 1 at a clock edge: latch rw, address and data_in.
  - Load the counter with WAIT_CYCLES, then go to WAIT.
  - All other inputs are ignored.
- **WAIT**
  - If mov=0 at an edge: abort, return to IDLE. No write is performed, moc stays 0.
  - Else if counter=0: perform the access, then go to DONE with moc=1.
  - Else: decrement the counter.
  - Changes on enable, address or data_in after capture are ignored.
- **Access**
  - Fault when the latched address[1:0]≠0 or the latched address ≥ 4*DEPTH.
  - On a fault: no storage change, data_out=0, err=1.
  - Otherwise, read: data_out = mem[address>>2], err=0.
  - Otherwise, write: mem[address>>2] = data_in, data_out unchanged, err=0.
- **DONE**
  - moc, data_out and err are held stable.
  - When mov=0 at an edge: moc=0, err=0, go to IDLE.
  - A new request is only accepted from IDLE, on a later edge.
- **Storage**: DEPTH×32 registers, not cleared by reset; contents are undefined until written.
- **Counter**: 4 bits; WAIT_CYCLES > 15 is illegal.

## Timing
- Reset values: state=IDLE, moc=0, err=0, data_out=0, counter=0.
- Asserting reset in any state forces these values immediately. An in-flight write that has not reached DONE is dropped.
- Latency: request sampled at edge N; moc rises after edge N+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: moc high after edge N+1.
  - WAIT_CYCLES=2: moc high after edge N+3.
- A write commits on the same edge that raises moc.
- Read data is valid on the same edge as moc and stays valid until the moc fall.
- moc falls on the first edge at which mov=0 in DONE.
- Minimum back-to-back spacing: one IDLE cycle between transactions.
- mov=1 with enable=0 in IDLE: no request, state unchanged.
- mov deasserted in the same cycle the counter reaches 0: the abort wins; no access, no moc.

## Test plan
1. **Write then read.** With WAIT_CYCLES=2:
   - Write 0xDEADBEEF to address 0x10; moc rises exactly 3 edges after capture.
   - Drop mov; moc falls on the next edge.
   - Read 0x10: data_out=0xDEADBEEF with moc=1, err=0.
2. **Zero-wait configuration.** With WAIT_CYCLES=0:
   - Write 0x12345678 to 0x1FC (last word of 128).
   - Read it back: moc high one edge after capture, data_out=0x12345678.
3. **Faults.**
   - Read 0x0000_0202 (misaligned): moc=1, err=1, data_out=0.
   - Write 0x200 (out of range): moc=1, err=1. A subsequent read of 0x0 returns its prior value.
4. **Abort.**
   - Write 0xAAAA5555 to 0x20 with mov dropped after one WAIT edge: moc never rises, state returns to IDLE.
   - A read of 0x20 returns the earlier contents.
5. **Reset mid-operation.**
   - Pull reset low during WAIT of a write to 0x30, between clock edges: moc, err and data_out go to 0 immediately.
   - After release, a read of 0x30 shows the old value.
6. **Handshake hold and input changes.**
   - Keep mov high for 5 cycles in DONE: moc and data_out stay stable for all 5.
   - Change address and data_in while in DONE: no effect.
   - A new request is accepted only after moc has returned to 0.
